// File: rtl/soc_console_ctrl.sv
// Text console engine: buffers CPU character codes in a FIFO and turns them into
// single-byte writes to the video character RAM, with cursor, scrolling and clears.
module soc_console_ctrl #(
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  BLANK      = 8'h20
) (
  input  logic        clk_cpu,
  input  logic        n_reset,
  input  logic        sel,
  input  logic [3:0]  wren,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ram_we,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic [4:0]  scroll_row
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [5:0]  COLS_W   = 6'(COLS);
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0]  ROWS_W   = 5'(ROWS);

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StAdvance,
    StClearLine,
    StClearAll
  } state_e;

  state_e             r_state;
  logic [7:0]         r_cur;
  logic [5:0]         r_x;
  logic [4:0]         r_y;
  logic [4:0]         r_scroll;
  logic [4:0]         r_clr_row;
  logic [5:0]         r_clr_col;
  logic [10:0]        r_clr_addr;
  logic               r_ram_we;
  logic [10:0]        r_ram_addr;
  logic [7:0]         r_ram_wdata;

  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_wr;
  logic               w_data_wr;
  logic               w_ctrl_wr;
  logic               w_flush;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_busy;
  logic [4:0]         w_phys_row;
  logic [5:0]         w_x_inc;
  logic               w_unused_data;

  assign w_wr          = sel & (|wren);
  assign w_data_wr     = w_wr && (reg_addr == 2'd0);
  assign w_ctrl_wr     = w_wr && (reg_addr == 2'd1);
  assign w_flush       = w_ctrl_wr && data_in[0];
  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push        = w_data_wr && !w_full;
  assign w_pop         = (r_state == StIdle) && (r_count != '0) && !w_flush;
  assign w_busy        = (r_state != StIdle) || (r_count != '0);
  assign w_phys_row    = r_scroll + r_y;
  assign w_x_inc       = r_x + 6'd1;
  assign w_unused_data = ^data_in[31:8];

  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign scroll_row = r_scroll;

  always_ff @(posedge clk_cpu) begin
    if (w_push && !w_flush) r_fifo[r_wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
      if (w_data_wr && w_full)             r_ovf <= 1'b1;
      else if (w_ctrl_wr && data_in[1])    r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= StClearAll;
      r_cur       <= 8'h00;
      r_x         <= '0;
      r_y         <= '0;
      r_scroll    <= '0;
      r_clr_row   <= '0;
      r_clr_col   <= '0;
      r_clr_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= BLANK;
    end else begin
      r_ram_we <= 1'b0;
      if (w_flush) begin
        // A console reset beats whatever fill or character is in flight.
        r_state    <= StClearAll;
        r_clr_addr <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_pop) begin
              r_cur   <= r_fifo[r_rd_ptr];
              r_state <= StExec;
            end
          end
          StExec: begin
            case (r_cur)
              8'h0D: begin
                r_x     <= '0;
                r_state <= StIdle;
              end
              8'h0A: begin
                r_x     <= '0;
                r_state <= StAdvance;
              end
              8'h08: begin
                if (r_x != '0) begin
                  r_x         <= r_x - 6'd1;
                  r_ram_we    <= 1'b1;
                  r_ram_addr  <= {w_phys_row, r_x - 6'd1};
                  r_ram_wdata <= BLANK;
                end
                r_state <= StIdle;
              end
              default: begin
                r_ram_we    <= 1'b1;
                r_ram_addr  <= {w_phys_row, r_x};
                r_ram_wdata <= r_cur;
                if (w_x_inc == COLS_W) begin
                  r_x     <= '0;
                  r_state <= StAdvance;
                end else begin
                  r_x     <= w_x_inc;
                  r_state <= StIdle;
                end
              end
            endcase
          end
          StAdvance: begin
            if (r_y < LAST_ROW) begin
              r_y     <= r_y + 5'd1;
              r_state <= StIdle;
            end else begin
              // New bottom row is (scroll + 1) + (ROWS - 1).
              r_scroll  <= r_scroll + 5'd1;
              r_clr_row <= r_scroll + ROWS_W;
              r_clr_col <= '0;
              r_state   <= StClearLine;
            end
          end
          StClearLine: begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= {r_clr_row, r_clr_col};
            r_ram_wdata <= BLANK;
            if (r_clr_col == LAST_COL) r_state <= StIdle;
            else                       r_clr_col <= r_clr_col + 6'd1;
          end
          StClearAll: begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_clr_addr;
            r_ram_wdata <= BLANK;
            if (r_clr_addr == 11'h7FF) begin
              r_x      <= '0;
              r_y      <= '0;
              r_scroll <= '0;
              r_state  <= StIdle;
            end else begin
              r_clr_addr <= r_clr_addr + 11'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (reg_addr == 2'd2) begin
      data_out[0]     = w_busy;
      data_out[1]     = r_ovf;
      data_out[5:2]   = 4'(r_count);
      data_out[13:8]  = r_x;
      data_out[20:16] = r_y;
      data_out[28:24] = r_scroll;
    end
  end

endmodule

// File: tb/tb_soc_console_ctrl.sv
// Bench for soc_console_ctrl: randomized character streams checked against a
// screen-level model of cursor, scroll and expected RAM write sequence.
module tb_soc_console_ctrl;
  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int DEPTH = 8;
  localparam logic [7:0] BLANK = 8'h20;

  logic        clk_cpu  = 1'b0;
  logic        n_reset  = 1'b0;
  logic        sel      = 1'b0;
  logic [3:0]  wren     = 4'h0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] data_in  = 32'h0;
  logic [31:0] data_out;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [4:0]  scroll_row;

  soc_console_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .FIFO_DEPTH(DEPTH),
    .BLANK     (BLANK)
  ) dut (
    .clk_cpu   (clk_cpu),
    .n_reset   (n_reset),
    .sel       (sel),
    .wren      (wren),
    .reg_addr  (reg_addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .scroll_row(scroll_row)
  );

  always #5 clk_cpu = ~clk_cpu;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cyc;
  int d_first;

  int obs_addr[$];
  int obs_data[$];
  int obs_cyc[$];
  int exp_addr[$];
  int exp_data[$];

  // Screen model: cursor, scroll offset and the ordered list of cell writes.
  int m_x, m_y, m_sc;

  always @(posedge clk_cpu) cyc <= cyc + 1;

  always @(posedge clk_cpu) begin
    #3;
    if (ram_we === 1'b1) begin
      obs_addr.push_back(int'(ram_addr));
      obs_data.push_back(int'(ram_wdata));
      obs_cyc.push_back(cyc);
    end
  end

  function automatic void m_expect(input int a, input int d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endfunction

  function automatic int m_row();
    return (m_sc + m_y) % 32;
  endfunction

  function automatic void m_advance();
    if (m_y < ROWS - 1) m_y++;
    else begin
      m_sc = (m_sc + 1) % 32;
      for (int c = 0; c < COLS; c++) m_expect(((m_sc + ROWS - 1) % 32) * 64 + c, BLANK);
    end
  endfunction

  function automatic void m_put(input int c);
    if (c == 'h0D) m_x = 0;
    else if (c == 'h0A) begin
      m_x = 0;
      m_advance();
    end else if (c == 'h08) begin
      if (m_x > 0) begin
        m_x--;
        m_expect(m_row() * 64 + m_x, BLANK);
      end
    end else begin
      m_expect(m_row() * 64 + m_x, c);
      m_x++;
      if (m_x == COLS) begin
        m_x = 0;
        m_advance();
      end
    end
  endfunction

  function automatic void m_clear_all();
    for (int a = 0; a < 2048; a++) m_expect(a, BLANK);
    m_x = 0; m_y = 0; m_sc = 0;
  endfunction

  function automatic int diff_writes();
    int bad, n;
    bad = 0;
    d_first = -1;
    n = (obs_addr.size() > exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      if (i >= obs_addr.size() || i >= exp_addr.size() ||
          obs_addr[i] != exp_addr[i] || obs_data[i] != exp_data[i]) begin
        bad++;
        if (d_first < 0) d_first = i;
      end
    end
    return bad;
  endfunction

  task automatic clear_queues();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_cpu);
    sel      = 1'b1;
    wren     = 4'($urandom_range(1, 15));
    reg_addr = a;
    data_in  = d;
    @(negedge clk_cpu);
    acc_cyc  = cyc;
    sel      = 1'b0;
    wren     = 4'h0;
  endtask

  task automatic read_status(output logic [31:0] s);
    @(negedge clk_cpu);
    sel      = 1'b1;
    wren     = 4'h0;
    reg_addr = 2'd2;
    #1 s = data_out;
  endtask

  task automatic send_char(input logic [7:0] c);
    logic [31:0] s;
    int guard;
    guard = 0;
    read_status(s);
    while (int'(s[5:2]) >= DEPTH && guard < 1000) begin
      read_status(s);
      guard++;
    end
    bus_write(2'd0, {24'h0, c});
    m_put(int'(c));
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      read_status(s);
      if (s[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk_cpu);
  endtask

  task automatic test_reset();
    logic [31:0] s;
    bit ok;
    int bad, rel;
    n_reset = 1'b0;
    repeat (3) @(negedge clk_cpu);
    n_chk++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b want 0", ram_we); else n_pass++;
    n_chk++; if (ram_addr !== 11'h0) $display("FAIL reset_ram_addr: got %h want 000", ram_addr); else n_pass++;
    n_chk++; if (ram_wdata !== BLANK) $display("FAIL reset_ram_wdata: got %h want %h", ram_wdata, BLANK); else n_pass++;
    n_chk++; if (scroll_row !== 5'd0) $display("FAIL reset_scroll: got %0d want 0", scroll_row); else n_pass++;
    clear_queues();
    n_reset = 1'b1;
    rel = cyc;
    m_clear_all();
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL reset_idle_timeout: got busy want idle"); else n_pass++;
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL reset_clear_writes: got %0d bad (obs %0d exp %0d first %0d) want 0",
                            bad, obs_addr.size(), exp_addr.size(), d_first);
    else n_pass++;
    n_chk++;
    if (obs_cyc.size() != 2048 || obs_cyc[0] != rel + 1 || obs_cyc[2047] - obs_cyc[0] != 2047)
      $display("FAIL reset_clear_timing: got n=%0d first=%0d want n=2048 first=%0d consecutive",
               obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, rel + 1);
    else n_pass++;
    read_status(s);
    n_chk++; if (s[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", s[0]); else n_pass++;
    n_chk++;
    if (s[13:8] !== 6'd0 || s[20:16] !== 5'd0)
      $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", s[13:8], s[20:16]);
    else n_pass++;
    n_chk++; if (s[28:24] !== 5'd0) $display("FAIL reset_status_scroll: got %0d want 0", s[28:24]); else n_pass++;
    @(negedge clk_cpu);
    reg_addr = 2'd1;
    #1;
    n_chk++; if (data_out !== 32'h0) $display("FAIL read_other_reg: got %h want 0", data_out); else n_pass++;
    clear_queues();
  endtask

  task automatic test_print();
    logic [31:0] s;
    bit ok;
    int bad, a0;
    send_char(8'h41);
    a0 = acc_cyc;
    send_char(8'h42);
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL print_idle_timeout: got busy want idle"); else n_pass++;
    n_chk++;
    if (obs_cyc.size() == 0 || obs_cyc[0] != a0 + 2)
      $display("FAIL print_latency: got %0d want %0d", (obs_cyc.size() > 0) ? obs_cyc[0] - a0 : -1, 2);
    else n_pass++;
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL print_writes: got %0d bad (first %0d) want 0", bad, d_first);
    else n_pass++;
    read_status(s);
    n_chk++; if (s[13:8] !== 6'd2) $display("FAIL print_cursor_x: got %0d want 2", s[13:8]); else n_pass++;
    clear_queues();
  endtask

  task automatic test_wrap();
    logic [31:0] s;
    bit ok;
    int bad;
    send_char(8'h0D);
    repeat (COLS) send_char(8'h2A);
    wait_idle(ok);
    read_status(s);
    n_chk++;
    if (s[13:8] !== 6'd0 || s[20:16] !== 5'd1)
      $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", s[13:8], s[20:16]);
    else n_pass++;
    send_char(8'h5A);
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL wrap_idle_timeout: got busy want idle"); else n_pass++;
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL wrap_writes: got %0d bad (first %0d) want 0", bad, d_first);
    else n_pass++;
    n_chk++;
    if (obs_addr.size() == 0 || obs_addr[obs_addr.size() - 1] != 'h040)
      $display("FAIL wrap_next_addr: got %h want 040",
               (obs_addr.size() > 0) ? obs_addr[obs_addr.size() - 1] : -1);
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_scroll();
    logic [31:0] s;
    bit ok;
    int bad, lf;
    send_char(8'h0D);
    while (m_y < ROWS - 1) send_char(8'h0A);
    wait_idle(ok);
    clear_queues();
    read_status(s);
    n_chk++;
    if (s[20:16] !== 5'd29 || s[28:24] !== 5'd0)
      $display("FAIL scroll_pre: got y=%0d scroll=%0d want y=29 scroll=0", s[20:16], s[28:24]);
    else n_pass++;
    send_char(8'h0A);
    lf = acc_cyc;
    wait_idle(ok);
    n_chk++;
    if (obs_addr.size() != COLS || obs_addr[0] != 'h780 || obs_cyc[0] != lf + 4)
      $display("FAIL scroll_clear_line: got n=%0d addr0=%h dt=%0d want n=40 addr0=780 dt=4",
               obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1,
               (obs_cyc.size() > 0) ? obs_cyc[0] - lf : -1);
    else n_pass++;
    n_chk++; if (scroll_row !== 5'd1) $display("FAIL scroll_port: got %0d want 1", scroll_row); else n_pass++;
    send_char(8'h51);
    wait_idle(ok);
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL scroll_writes: got %0d bad (first %0d) want 0", bad, d_first);
    else n_pass++;
    read_status(s);
    n_chk++;
    if (s[13:8] !== 6'd1 || s[20:16] !== 5'd29 || s[28:24] !== 5'd1)
      $display("FAIL scroll_status: got x=%0d y=%0d sc=%0d want 1 29 1", s[13:8], s[20:16], s[28:24]);
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_backspace();
    logic [31:0] s;
    bit ok;
    int bad;
    send_char(8'h0D);
    repeat (3) send_char(8'($urandom_range('h21, 'h7E)));
    wait_idle(ok);
    clear_queues();
    send_char(8'h08);
    wait_idle(ok);
    bad = diff_writes();
    n_chk++;
    if (bad !== 0 || obs_addr.size() != 1)
      $display("FAIL bs_blank_write: got %0d bad n=%0d want 0 bad n=1", bad, obs_addr.size());
    else n_pass++;
    read_status(s);
    n_chk++; if (s[13:8] !== 6'd2) $display("FAIL bs_cursor_x: got %0d want 2", s[13:8]); else n_pass++;
    send_char(8'h0D);
    wait_idle(ok);
    clear_queues();
    send_char(8'h08);
    wait_idle(ok);
    n_chk++;
    if (obs_addr.size() != 0) $display("FAIL bs_at_col0: got %0d writes want 0", obs_addr.size());
    else n_pass++;
    read_status(s);
    n_chk++; if (s[13:8] !== 6'd0) $display("FAIL bs_col0_x: got %0d want 0", s[13:8]); else n_pass++;
    clear_queues();
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    bit ok;
    int bad;
    logic [7:0] c;
    bus_write(2'd1, 32'h1);
    m_clear_all();
    for (int i = 0; i < DEPTH + 1; i++) begin
      c = 8'($urandom_range('h21, 'h7E));
      bus_write(2'd0, {24'h0, c});
      if (i < DEPTH) m_put(int'(c));
    end
    read_status(s);
    n_chk++;
    if (s[1] !== 1'b1 || s[5:2] !== 4'd8 || s[0] !== 1'b1)
      $display("FAIL ovf_set: got ovf=%b cnt=%0d busy=%b want 1 8 1", s[1], s[5:2], s[0]);
    else n_pass++;
    bus_write(2'd1, 32'h2);
    read_status(s);
    n_chk++;
    if (s[1] !== 1'b0 || s[5:2] !== 4'd8)
      $display("FAIL ovf_clear: got ovf=%b cnt=%0d want 0 8", s[1], s[5:2]);
    else n_pass++;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL ovf_idle_timeout: got busy want idle"); else n_pass++;
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL ovf_writes: got %0d bad (obs %0d exp %0d first %0d) want 0",
                            bad, obs_addr.size(), exp_addr.size(), d_first);
    else n_pass++;
    read_status(s);
    n_chk++;
    if (s[13:8] !== 6'(m_x) || s[20:16] !== 5'(m_y))
      $display("FAIL ovf_cursor: got (%0d,%0d) want (%0d,%0d)", s[13:8], s[20:16], m_x, m_y);
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_abort();
    logic [31:0] s;
    bit ok;
    int bad, fl;
    while (m_y < ROWS - 1) send_char(8'h0A);
    wait_idle(ok);
    clear_queues();
    send_char(8'h0A);
    repeat (12) @(negedge clk_cpu);
    bus_write(2'd0, 32'h4B);
    bus_write(2'd0, 32'h4C);
    read_status(s);
    n_chk++;
    if (s[5:2] !== 4'd2 || s[0] !== 1'b1)
      $display("FAIL abort_push_during_fill: got cnt=%0d busy=%b want 2 1", s[5:2], s[0]);
    else n_pass++;
    n_chk++;
    if (obs_addr.size() == 0 || obs_addr.size() >= COLS)
      $display("FAIL abort_mid_line: got %0d line writes want 1..39", obs_addr.size());
    else n_pass++;
    bus_write(2'd1, 32'h1);
    fl = acc_cyc;
    clear_queues();
    m_clear_all();
    read_status(s);
    n_chk++; if (s[5:2] !== 4'd0) $display("FAIL abort_flush_count: got %0d want 0", s[5:2]); else n_pass++;
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL abort_idle_timeout: got busy want idle"); else n_pass++;
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL abort_writes: got %0d bad (obs %0d exp %0d first %0d) want 0",
                            bad, obs_addr.size(), exp_addr.size(), d_first);
    else n_pass++;
    n_chk++;
    if (obs_cyc.size() == 0 || obs_cyc[0] != fl + 1)
      $display("FAIL abort_restart_time: got %0d want 1", (obs_cyc.size() > 0) ? obs_cyc[0] - fl : -1);
    else n_pass++;
    read_status(s);
    n_chk++;
    if (s[28:24] !== 5'd0 || scroll_row !== 5'd0 || s[13:8] !== 6'd0 || s[20:16] !== 5'd0)
      $display("FAIL abort_final_state: got sc=%0d x=%0d y=%0d want 0 0 0", s[28:24], s[13:8], s[20:16]);
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_random();
    logic [31:0] s;
    bit ok;
    int bad, r;
    logic [7:0] c;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) c = 8'h0D;
      else if (r <= 4) c = 8'h0A;
      else if (r == 5) c = 8'h08;
      else c = 8'($urandom_range(0, 255));
      send_char(c);
    end
    wait_idle(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL rand_idle_timeout: got busy want idle"); else n_pass++;
    bad = diff_writes();
    n_chk++;
    if (bad !== 0) $display("FAIL rand_writes: got %0d bad (obs %0d exp %0d first %0d) want 0",
                            bad, obs_addr.size(), exp_addr.size(), d_first);
    else n_pass++;
    read_status(s);
    n_chk++;
    if (s[13:8] !== 6'(m_x) || s[20:16] !== 5'(m_y) || s[28:24] !== 5'(m_sc) || s[1] !== 1'b0)
      $display("FAIL rand_status: got x=%0d y=%0d sc=%0d ovf=%b want %0d %0d %0d 0",
               s[13:8], s[20:16], s[28:24], s[1], m_x, m_y, m_sc);
    else n_pass++;
    n_chk++;
    if (scroll_row !== 5'(m_sc)) $display("FAIL rand_scroll_port: got %0d want %0d", scroll_row, m_sc);
    else n_pass++;
    clear_queues();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_print();
    test_wrap();
    test_scroll();
    test_backspace();
    test_overflow();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
